// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: ALU op encodings, multiply/divide FSM states
// and the M-extension op helpers used by decode, ALU and iter_muldiv.
package rv32_pkg;

   localparam int XLEN = 32;

   localparam logic [4:0] ALU_ADD    = 5'b00000;
   localparam logic [4:0] ALU_SUB    = 5'b00001;
   localparam logic [4:0] ALU_SLL    = 5'b00010;
   localparam logic [4:0] ALU_SLT    = 5'b00011;
   localparam logic [4:0] ALU_SLTU   = 5'b00100;
   localparam logic [4:0] ALU_XOR    = 5'b00101;
   localparam logic [4:0] ALU_SRL    = 5'b00110;
   localparam logic [4:0] ALU_SRA    = 5'b00111;
   localparam logic [4:0] ALU_OR     = 5'b01000;
   localparam logic [4:0] ALU_AND    = 5'b01001;
   localparam logic [4:0] ALU_LUI    = 5'b01010;
   localparam logic [4:0] ALU_MUL    = 5'b01011;
   localparam logic [4:0] ALU_MULH   = 5'b01100;
   localparam logic [4:0] ALU_MULHSU = 5'b01101;
   localparam logic [4:0] ALU_MULHU  = 5'b01110;
   localparam logic [4:0] ALU_DIV    = 5'b01111;
   localparam logic [4:0] ALU_DIVU   = 5'b10000;
   localparam logic [4:0] ALU_REM    = 5'b10001;
   localparam logic [4:0] ALU_REMU   = 5'b10010;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } md_state_e;

   function automatic logic is_m_op(input logic [4:0] op);
      return (op >= ALU_MUL) && (op <= ALU_REMU);
   endfunction

   function automatic logic is_div_op(input logic [4:0] op);
      return (op >= ALU_DIV) && (op <= ALU_REMU);
   endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: one bit per cycle
// over 32 cycles, sharing a single 64-bit accumulator between mul and div.
module iter_muldiv
   import rv32_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [4:0]      alu_op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   md_state_e         state;
   logic [CNT_W-1:0]  cnt;
   logic [4:0]        op_q;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opd;
   logic              neg_q;
   logic              neg_r;

   logic            a_sgn, b_sgn, in_div, in_rem;
   logic            div_zero, div_ovf, special;
   logic [XLEN-1:0] a_mag, b_mag, spec_res;

   assign a_sgn = op_a[XLEN-1] & ((alu_op == ALU_MUL) | (alu_op == ALU_MULH)
                | (alu_op == ALU_MULHSU) | (alu_op == ALU_DIV) | (alu_op == ALU_REM));
   assign b_sgn = op_b[XLEN-1] & ((alu_op == ALU_MUL) | (alu_op == ALU_MULH)
                | (alu_op == ALU_DIV) | (alu_op == ALU_REM));
   assign a_mag = a_sgn ? -op_a : op_a;
   assign b_mag = b_sgn ? -op_b : op_b;

   assign in_div   = is_div_op(alu_op);
   assign in_rem   = (alu_op == ALU_REM) | (alu_op == ALU_REMU);
   assign div_zero = in_div & (op_b == '0);
   assign div_ovf  = ((alu_op == ALU_DIV) | (alu_op == ALU_REM))
                   & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
   assign special  = div_zero | div_ovf;

   // Overflow leaves only DIV (-> most negative) and REM (-> 0) to decode.
   assign spec_res = div_zero ? (in_rem ? op_a : '1)
                   : (alu_op == ALU_DIV) ? {1'b1, {(XLEN-1){1'b0}}}
                   : '0;

   logic [XLEN:0]     mul_sum, div_trial;
   logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod;
   logic [XLEN-1:0]   quo, rem, fin;

   assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]}
                    + (acc[0] ? {1'b0, opd} : '0);
   assign mul_next  = {mul_sum, acc[XLEN-1:1]};
   assign div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opd};
   assign div_next  = div_trial[XLEN]
                    ? {acc[2*XLEN-2:0], 1'b0}
                    : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
   assign acc_next  = is_div_op(op_q) ? div_next : mul_next;

   assign prod = neg_q ? -acc_next : acc_next;
   assign quo  = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
   assign rem  = neg_r ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];

   always_comb begin
      fin = '0;
      unique case (op_q)
         ALU_MUL:                        fin = prod[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU: fin = prod[2*XLEN-1:XLEN];
         ALU_DIV, ALU_DIVU:              fin = quo;
         ALU_REM, ALU_REMU:              fin = rem;
         default:                        fin = '0;
      endcase
   end

   assign busy  = (state != IDLE);
   assign stall = (state == CALC)
                | ((state == IDLE) & start & is_m_op(alu_op));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= '0;
         acc    <= '0;
         opd    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!flush && start && is_m_op(alu_op)) begin
                  op_q <= alu_op;
                  cnt  <= '0;
                  if (special) begin
                     result <= spec_res;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     neg_q <= a_sgn ^ b_sgn;
                     neg_r <= a_sgn;
                     acc   <= {{XLEN{1'b0}}, in_div ? a_mag : b_mag};
                     opd   <= in_div ? b_mag : a_mag;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  acc <= acc_next;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(XLEN-1)) begin
                     result <= fin;
                     done   <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_muldiv.sv
// Randomized and directed bench for iter_muldiv against an arithmetic
// reference of the RV32M semantics.
module tb_iter_muldiv;
   import rv32_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [4:0]  alu_op = '0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        busy, stall, done;
   logic [31:0] result;

   iter_muldiv #(.XLEN(32), .CNT_W(5)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .alu_op (alu_op),
      .op_a   (op_a),
      .op_b   (op_b),
      .flush  (flush),
      .busy   (busy),
      .stall  (stall),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [4:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      int          si, sj;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      si = a;
      sj = b;
      case (op)
         ALU_MUL:    begin p = sa * sb; return p[31:0];  end
         ALU_MULH:   begin p = sa * sb; return p[63:32]; end
         ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
         ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
         ALU_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(si / sj);
         end
         ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         ALU_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(si % sj);
         end
         ALU_REMU: return (b == 0) ? a : a % b;
         default:  return 32'h0;
      endcase
   endfunction

   function automatic int model_lat(input logic [4:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
      if (op >= ALU_DIV && b == 0) return 1;
      if ((op == ALU_DIV || op == ALU_REM)
          && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Issue one op from IDLE, scramble inputs after acceptance, and
   // optionally re-pulse start while busy at cycle poke_at.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int exp_lat, input int poke_at);
      int          lat = 0;
      int          gaps = 0;
      logic [31:0] got = '0;
      @(negedge clk);
      start = 1'b1; alu_op = op; op_a = a; op_b = b;
      #1 check("stall_req", {63'b0, stall}, 64'd1);
      for (int c = 1; c <= 40 && lat == 0; c++) begin
         @(negedge clk);
         start  = (c == poke_at);
         alu_op = (c == poke_at) ? ALU_MULHU : 5'($urandom_range(11, 18));
         op_a   = $urandom;
         op_b   = $urandom;
         if (done) begin
            lat = c;
            got = result;
            check("stall_done", {63'b0, stall}, 64'd0);
         end else if (!stall) begin
            gaps++;
         end
      end
      start = 1'b0;
      check("result", {32'b0, got}, {32'b0, exp});
      check("latency", 64'(lat), 64'(exp_lat));
      check("stall_gap", 64'(gaps), 64'd0);
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 9))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t dir[$] = '{
      '{ALU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33},
      '{ALU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33},
      '{ALU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33},
      '{ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
      '{ALU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33},
      '{ALU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33},
      '{ALU_DIVU,   32'd100,        32'd7,         32'd14,        33},
      '{ALU_REMU,   32'd100,        32'd7,         32'd2,         33},
      '{ALU_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1},
      '{ALU_REM,    32'd5,          32'd0,         32'd5,         1},
      '{ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1},
      '{ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1}
   };

   initial begin
      logic [31:0] prev;
      logic [4:0]  rop;
      logic [31:0] ra, rb;
      int          pulses;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy",   {63'b0, busy},   64'd0);
      check("rst_done",   {63'b0, done},   64'd0);
      check("rst_result", {32'b0, result}, 64'd0);
      check("rst_stall",  {63'b0, stall},  64'd0);
      rst = 1'b0;

      @(negedge clk);
      start = 1'b1; alu_op = ALU_ADD; op_a = 32'd1; op_b = 32'd2;
      #1 check("nonm_stall", {63'b0, stall}, 64'd0);
      @(negedge clk);
      start = 1'b0;
      check("nonm_busy", {63'b0, busy}, 64'd0);

      foreach (dir[i])
         run_op(dir[i].op, dir[i].a, dir[i].b, dir[i].exp, dir[i].lat, 0);

      run_op(ALU_MUL, 32'h0000_1234, 32'h0000_5678,
             model(ALU_MUL, 32'h0000_1234, 32'h0000_5678), 33, 5);

      prev = result;
      pulses = 0;
      @(negedge clk);
      start = 1'b1; alu_op = ALU_MUL; op_a = 32'd9; op_b = 32'd9;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         flush = (c == 10);
         if (c == 11) check("flush_idle", {63'b0, busy}, 64'd0);
         if (done) pulses++;
      end
      flush = 1'b0;
      check("flush_done", 64'(pulses), 64'd0);
      check("flush_res", {32'b0, result}, {32'b0, prev});

      @(negedge clk);
      start = 1'b1; flush = 1'b1; alu_op = ALU_MUL;
      op_a = 32'd5; op_b = 32'd6;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_win", {63'b0, busy}, 64'd0);
      check("flush_win_res", {32'b0, result}, {32'b0, prev});

      @(negedge clk);
      start = 1'b1; alu_op = ALU_DIVU; op_a = 32'd1000; op_b = 32'd3;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      #1;
      check("mid_rst_busy", {63'b0, busy},   64'd0);
      check("mid_rst_done", {63'b0, done},   64'd0);
      check("mid_rst_res",  {32'b0, result}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(ALU_MUL, 32'd3, 32'd4, 32'd12, 33, 0);

      for (int i = 0; i < 40; i++) begin
         rop = 5'($urandom_range(11, 18));
         ra  = pick_val();
         rb  = pick_val();
         run_op(rop, ra, rb, model(rop, ra, rb), model_lat(rop, ra, rb), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
